// File: rtl/oram_path_server.sv
// ORAM path server: owns every bucket of the tree, clears it after reset, and streams or stores
// one root-to-leaf path per request. Define ORAM_CLEAR_ON_READ_EN to drop the tree copy of each bucket when it is read.
module oram_path_server #(
  parameter  int D  = 6,
  parameter  int K  = 3,
  parameter  int A  = 8,
  localparam int TW = 2*D + 8*A + 2,
  localparam int BW = K*TW,
  localparam int LW = $clog2(D)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          init_busy_o,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_write_i,
  input  logic [D-2:0]  req_leaf_i,
  output logic          rd_valid_o,
  input  logic          rd_ready_i,
  output logic [BW-1:0] rd_bucket_o,
  output logic [LW-1:0] rd_level_o,
  output logic          rd_last_o,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  input  logic [BW-1:0] wr_bucket_i,
  input  logic          wr_last_i,
  output logic          done_o,
  output logic          err_o
);

  localparam int          NODES    = (1 << D) - 1;
  localparam logic [LW-1:0] LAST_LVL = LW'(D-1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD_ADDR,
    S_RD_OUT,
    S_WR_IN
  } state_t;

  state_t        state_q, state_d;
  logic [D-1:0]  init_addr_q, init_addr_d;
  logic [LW-1:0] level_q, level_d;
  logic [D-1:0]  node_q, node_d;
  logic [D-2:0]  leaf_q, leaf_d;
  logic [BW-1:0] rd_data_q, rd_data_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [BW-1:0] mem_q [NODES];
  logic          mem_we;
  logic [D-1:0]  mem_waddr;
  logic [BW-1:0] mem_wdata;

  logic          leaf_bit;
  logic [D-1:0]  child;
  logic          at_leaf;

`ifdef ORAM_CLEAR_ON_READ_EN
  function automatic logic [BW-1:0] clear_empty(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int j = 0; j < K; j++) r[j*TW + TW-1] = 1'b0;
    return r;
  endfunction
`endif

  // Child selection walks the leaf id LSB first: level L picks by leaf bit L.
  always_comb begin
    leaf_bit = 1'b0;
    for (int i = 0; i < D-1; i++) begin
      if (level_q == LW'(i)) leaf_bit = leaf_q[i];
    end
    child   = {node_q[D-2:0], leaf_bit};
    at_leaf = (level_q == LAST_LVL);
  end

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    level_d     = level_q;
    node_d      = node_q;
    leaf_d      = leaf_q;
    rd_data_d   = rd_data_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = node_q - D'(1);
    mem_wdata   = wr_bucket_i;
    init_busy_o = 1'b0;
    req_ready_o = 1'b0;
    rd_valid_o  = 1'b0;
    wr_ready_o  = 1'b0;

    case (state_q)
      S_INIT: begin
        init_busy_o = 1'b1;
        mem_we      = 1'b1;
        mem_waddr   = init_addr_q;
        mem_wdata   = '0;
        if (init_addr_q == D'(NODES-1)) begin
          init_addr_d = '0;
          state_d     = S_IDLE;
        end else begin
          init_addr_d = init_addr_q + D'(1);
        end
      end
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          leaf_d  = req_leaf_i;
          level_d = '0;
          node_d  = D'(1);
          state_d = req_write_i ? S_WR_IN : S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        rd_data_d = mem_q[node_q - D'(1)];
        state_d   = S_RD_OUT;
      end
      S_RD_OUT: begin
        rd_valid_o = 1'b1;
        if (rd_ready_i) begin
`ifdef ORAM_CLEAR_ON_READ_EN
          mem_we    = 1'b1;
          mem_wdata = clear_empty(rd_data_q);
`endif
          if (at_leaf) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            level_d = level_q + LW'(1);
            node_d  = child;
            state_d = S_RD_ADDR;
          end
        end
      end
      S_WR_IN: begin
        wr_ready_o = 1'b1;
        if (wr_valid_i) begin
          // A misplaced wr_last is flagged but the level count still decides completion.
          mem_we = 1'b1;
          err_d  = (wr_last_i != at_leaf);
          if (at_leaf) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            level_d = level_q + LW'(1);
            node_d  = child;
          end
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_INIT;
      init_addr_q <= '0;
      level_q     <= '0;
      node_q      <= D'(1);
      leaf_q      <= '0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      level_q     <= level_d;
      node_q      <= node_d;
      leaf_q      <= leaf_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) mem_q[mem_waddr] <= mem_wdata;
  end

  assign rd_bucket_o = rd_data_q;
  assign rd_level_o  = level_q;
  assign rd_last_o   = rd_valid_o & at_leaf;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_oram_path_server.sv
// Scoreboard bench for oram_path_server: stimulus queues expected beats and pulses, a negedge monitor checks them.
module tb_oram_path_server;
  localparam int D = 6, K = 3, A = 8;
  localparam int TW = 2*D + 8*A + 2;
  localparam int BW = K*TW;
  localparam int LW = $clog2(D);
  localparam int NODES = (1 << D) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_busy, req_ready, rd_valid, rd_last, wr_ready, done, err;
  logic          req_valid = 1'b0, req_write = 1'b0, rd_ready = 1'b0, wr_valid = 1'b0, wr_last = 1'b0;
  logic [D-2:0]  req_leaf = '0;
  logic [BW-1:0] rd_bucket, wr_bucket = '0;
  logic [LW-1:0] rd_level;

  always #5 clk = ~clk;

  oram_path_server #(.D(D), .K(K), .A(A)) dut (
    .clk_i(clk), .rst_i(rst), .init_busy_o(init_busy),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write), .req_leaf_i(req_leaf),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_bucket_o(rd_bucket), .rd_level_o(rd_level),
    .rd_last_o(rd_last), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_bucket_i(wr_bucket),
    .wr_last_i(wr_last), .done_o(done), .err_o(err)
  );

  typedef struct {
    logic [BW-1:0] bucket;
    logic [LW-1:0] level;
    logic          last;
  } rd_exp_t;
  typedef struct {
    logic err;
    logic done;
  } wr_exp_t;

  rd_exp_t       rd_q[$];
  wr_exp_t       wr_q[$];
  logic [BW-1:0] model [NODES];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] clr(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int j = 0; j < K; j++) r[j*TW + TW-1] = 1'b0;
    return r;
  endfunction

  // Tuple: empty_n, pos, pos_empty_n, b_number, val, val_empty_n; val = beat+1, pos = tuple index.
  function automatic logic [BW-1:0] mk_bucket(input int i);
    logic [BW-1:0] b;
    logic [TW-1:0] t;
    for (int j = 0; j < K; j++) begin
      t = {1'b1, 5'(j), 1'b1, 6'(i), 64'(i + 1), 1'b1};
      b[j*TW +: TW] = t;
    end
    return b;
  endfunction

  // Monitor
  logic          pend_done = 1'b0, pend_err = 1'b0, stall_q = 1'b0;
  logic [BW-1:0] held_bucket;
  logic [LW-1:0] held_level;
  rd_exp_t       me;
  wr_exp_t       mw;

  always @(negedge clk) begin
    if (rst) begin
      pend_done = 1'b0;
      pend_err  = 1'b0;
      stall_q   = 1'b0;
    end else begin
      if (pend_done || done) chk("done_pulse", 256'(done), 256'(pend_done));
      if (pend_err || err) chk("err_pulse", 256'(err), 256'(pend_err));
      pend_done = 1'b0;
      pend_err  = 1'b0;
      if (stall_q) begin
        chk("stall_valid", 256'(rd_valid), 256'(1'b1));
        chk("stall_bucket", 256'(rd_bucket), 256'(held_bucket));
        chk("stall_level", 256'(rd_level), 256'(held_level));
      end
      stall_q = 1'b0;
      if (rd_valid && rd_ready) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: beat at level %0d, none expected", rd_level);
        end else begin
          me = rd_q.pop_front();
          chk("rd_bucket", 256'(rd_bucket), 256'(me.bucket));
          chk("rd_level", 256'(rd_level), 256'(me.level));
          chk("rd_last", 256'(rd_last), 256'(me.last));
          pend_done = me.last;
        end
      end else if (rd_valid) begin
        stall_q     = 1'b1;
        held_bucket = rd_bucket;
        held_level  = rd_level;
      end
      if (wr_valid && wr_ready) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected: write beat accepted, none expected");
        end else begin
          mw = wr_q.pop_front();
          pend_err  = mw.err;
          pend_done = mw.done;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    int n;
    rst = 1'b1; req_valid = 1'b0; wr_valid = 1'b0; wr_last = 1'b0; rd_ready = 1'b0;
    repeat (3) tick();
    chk("rst_init_busy", 256'(init_busy), 256'(1'b1));
    chk("rst_req_ready", 256'(req_ready), 256'(1'b0));
    chk("rst_rd_valid", 256'(rd_valid), 256'(1'b0));
    chk("rst_wr_ready", 256'(wr_ready), 256'(1'b0));
    chk("rst_done_err", 256'({done, err, rd_last}), 256'(3'b000));
    chk("rst_rd_level", 256'(rd_level), 256'(0));
    chk("rst_rd_bucket", 256'(rd_bucket), 256'(0));
    rst = 1'b0;
    for (int i = 0; i < NODES; i++) model[i] = '0;
    n = 0;
    while (init_busy && n < 200) begin
      tick();
      n++;
    end
    chk("init_cycles", 256'(n), 256'(63));
    chk("ready_after_init", 256'(req_ready), 256'(1'b1));
  endtask

  task automatic accept(input logic wr, input logic [D-2:0] leaf, output bit ok);
    int n;
    req_valid = 1'b1; req_write = wr; req_leaf = leaf;
    n = 0;
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_timeout: req_ready %b after %0d cycles, need 1", req_ready, n);
      req_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    tick();
    req_valid = 1'b0;
    req_leaf  = ~leaf;  // later changes must be ignored
    ok = 1'b1;
  endtask

  task automatic do_read(input logic [D-2:0] leaf, input bit stall, input bit chk_lat);
    rd_exp_t e;
    int      node, got, cyc, lat;
    bit      ok;
    node = 1;
    for (int l = 0; l < D; l++) begin
      e.bucket = model[node-1];
      e.level  = LW'(l);
      e.last   = (l == D-1);
      rd_q.push_back(e);
`ifdef ORAM_CLEAR_ON_READ_EN
      model[node-1] = clr(model[node-1]);
`endif
      if (l < D-1) node = 2*node + int'(leaf[l]);
    end
    accept(1'b0, leaf, ok);
    if (!ok) return;
    if (chk_lat) begin
      lat = 1;
      while (!rd_valid && lat < 10) begin
        tick();
        lat++;
      end
      chk("first_beat_latency", 256'(lat), 256'(2));
    end
    got = 0; cyc = 0;
    while (got < D && cyc < 400) begin
      rd_ready = stall ? (cyc % 3 == 2) : 1'b1;
      if (rd_valid && rd_ready) got++;
      tick();
      cyc++;
    end
    rd_ready = 1'b0;
    chk("rd_beats", 256'(got), 256'(D));
    chk("ready_in_done_cycle", 256'({req_ready, done}), 256'(2'b11));
    tick();
  endtask

  task automatic do_write(input logic [D-2:0] leaf, input logic [D-1:0] last_mask, input bit gap);
    logic [BW-1:0] data [D];
    wr_exp_t       w;
    int            node, n;
    bit            ok;
    node = 1;
    for (int i = 0; i < D; i++) begin
      data[i] = mk_bucket(i);
      model[node-1] = data[i];
      w.err  = (last_mask[i] != (i == D-1));
      w.done = (i == D-1);
      wr_q.push_back(w);
      if (i < D-1) node = 2*node + int'(leaf[i]);
    end
    accept(1'b1, leaf, ok);
    if (!ok) return;
    for (int i = 0; i < D; i++) begin
      if (gap && i == 1) begin
        wr_valid = 1'b0;
        tick();
      end
      wr_valid = 1'b1; wr_bucket = data[i]; wr_last = last_mask[i];
      n = 0;
      while (!wr_ready && n < 50) begin
        tick();
        n++;
      end
      chk("wr_ready_wait", 256'(n), 256'(0));
      tick();
    end
    wr_valid = 1'b0; wr_last = 1'b0;
    tick();
  endtask

  initial begin
    bit ok;
    wr_exp_t w;
    // 1: reset and tree clear
    do_reset();
    // 2: empty tree read with first-beat latency
    do_read(5'b10110, 1'b0, 1'b1);
    // 3: write a path, read it and paths sharing a prefix
    do_write(5'b00011, 6'b100000, 1'b0);
    do_read(5'b00011, 1'b0, 1'b0);
    do_read(5'b00010, 1'b0, 1'b0);
    do_read(5'b10011, 1'b0, 1'b0);
    // 4: stalled read
    do_read(5'b00011, 1'b1, 1'b0);
    // 5: wr_last early on beat 3 (and correct on beat 6) -> single err
    do_write(5'b10110, 6'b100100, 1'b1);
    do_read(5'b10110, 1'b0, 1'b0);
    // 6: reset during write beat 2
    do_write(5'b00011, 6'b100000, 1'b0);
    w.err = 1'b0; w.done = 1'b0;
    wr_q.push_back(w);
    accept(1'b1, 5'b01101, ok);
    wr_valid = 1'b1; wr_bucket = mk_bucket(0); wr_last = 1'b0;
    tick();
    wr_bucket = mk_bucket(1);
    rst = 1'b1;
    tick();
    do_reset();
    do_read(5'b01101, 1'b0, 1'b0);
    do_read(5'b00011, 1'b0, 1'b0);
    repeat (3) tick();
    chk("rd_queue_drained", 256'(rd_q.size()), 256'(0));
    chk("wr_queue_drained", 256'(wr_q.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at time %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
